// File: rtl/bias_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bias_sram_ctrl
// Purpose  : Initiator for the 384x32 bias SRAM. Bulk-loads bias words from a
//            valid/ready stream starting at address 0, then serves in-order,
//            fixed-latency (2 cycle), one-per-cycle reads per output channel.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            system clock (also the SRAM clock)
//   rst_n          asynchronous active-low reset
//   load_start_i   pulse: begin loading load_len_i words at address 0
//   load_len_i     word count; 0 = no writes, >DEPTH saturates to DEPTH
//   w_valid_i      load stream valid
//   w_data_i       load stream bias word
//   w_ready_o      load stream ready (LOAD state only)
//   load_done_o    one-cycle pulse on load completion
//   busy_o         load in progress or reads in flight
//   rd_req_i       read request for channel rd_ch_i
//   rd_ch_i        channel index / SRAM address
//   rd_ready_o     read request accepted when rd_req_i & rd_ready_o
//   rd_valid_o     rd_data_o valid, one cycle per accepted request
//   rd_data_o      bias word, returned in request order
//   rd_err_o       with rd_valid_o: channel out of range, data forced to 0
//   sram_cs_o      SRAM chip select
//   sram_oe_o      SRAM output enable
//   sram_web_o     SRAM write enable, active-low
//   sram_a_o       SRAM address
//   sram_di_o      SRAM write data
//   sram_do_i      SRAM read data, valid the cycle after a read access
// ============================================================================
module bias_sram_ctrl #(
  parameter int DEPTH = 384,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start_i,
  input  logic [AW-1:0] load_len_i,
  input  logic          w_valid_i,
  input  logic [DW-1:0] w_data_i,
  output logic          w_ready_o,
  output logic          load_done_o,
  output logic          busy_o,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_ch_i,
  output logic          rd_ready_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_err_o,
  output logic          sram_cs_o,
  output logic          sram_oe_o,
  output logic          sram_web_o,
  output logic [AW-1:0] sram_a_o,
  output logic [DW-1:0] sram_di_o,
  input  logic [DW-1:0] sram_do_i
);

  localparam logic [AW-1:0] C_DEPTH = AW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] len_q, len_d;

  // Read pipeline: stage 1 marks the cycle the SRAM drives DO,
  // stage 2 holds the returned word.
  logic          rd_v1_q;
  logic          rd_e1_q;
  logic          rd_valid_q;
  logic          rd_err_q;
  logic [DW-1:0] rd_data_q;

  logic          w_idle;
  logic          w_wr_beat;
  logic          w_rd_acc;
  logic          w_rd_inrange;
  logic [AW-1:0] w_len_sat;
  logic [AW-1:0] w_cnt_inc;

  assign w_idle       = (state_q == ST_IDLE);
  assign w_len_sat    = (load_len_i > C_DEPTH) ? C_DEPTH : load_len_i;
  assign w_cnt_inc    = cnt_q + AW'(1);
  assign w_wr_beat    = (state_q == ST_LOAD) && w_valid_i;
  // A same-cycle load_start takes priority over a read request.
  assign rd_ready_o   = w_idle && !load_start_i;
  assign w_rd_acc     = rd_req_i && rd_ready_o;
  assign w_rd_inrange = (rd_ch_i < C_DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          cnt_d   = '0;
          len_d   = w_len_sat;
          state_d = (w_len_sat == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_wr_beat) begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      rd_v1_q    <= 1'b0;
      rd_e1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      rd_v1_q    <= w_rd_acc;
      rd_e1_q    <= w_rd_acc && !w_rd_inrange;
      rd_valid_q <= rd_v1_q;
      rd_err_q   <= rd_v1_q && rd_e1_q;
      // rd_data holds its previous value between returns.
      if (rd_v1_q) rd_data_q <= rd_e1_q ? '0 : sram_do_i;
    end
  end

  // SRAM pins follow the current beat/request combinationally. Reads only
  // happen in IDLE, so a read and a write never share a cycle.
  assign sram_cs_o  = w_wr_beat || (w_rd_acc && w_rd_inrange);
  assign sram_oe_o  = w_rd_acc && w_rd_inrange;
  assign sram_web_o = !w_wr_beat;
  assign sram_a_o   = w_wr_beat ? cnt_q :
                      ((w_rd_acc && w_rd_inrange) ? rd_ch_i : '0);
  assign sram_di_o  = w_wr_beat ? w_data_i : '0;

  assign w_ready_o   = (state_q == ST_LOAD);
  assign load_done_o = (state_q == ST_DONE);
  assign busy_o      = !w_idle || rd_v1_q || rd_valid_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_err_o    = rd_err_q;
  assign rd_data_o   = rd_data_q;

endmodule
`default_nettype wire
